pci_hpram_arb: RTL and testbench
================================

PCI_HPRAM_ARB -- requirements
Module: pci_hpram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning HPRAM word-address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8'd200, meaning the pending-cycle count at which starvation is flagged.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, listed first as `PHY_CLK33_I  in  1  33 MHz PCI clock` and `PHY_RSTn_I  in  1  async active-low reset`.
REQ-004 SHALL have the PCI-side ports:
- HP_MEM_IDLE_I  in  1  PCI HPMEM manager idle (1 = port free)
- PCI_RAM_ADD_I  in  ADDR_W  PCI-side address
- PCI_RAM_DATA_I  in  32  PCI-side write data
- PCI_RAM_WEN_I  in  4  PCI-side byte write enables
- PCI_RAM_DATA_O  out  32  read data to PCI side
REQ-005 SHALL have the local-side ports:
- LOC_REQ_I  in  1  single-cycle request strobe
- LOC_WE_I  in  1  1 = write
- LOC_ADD_I  in  ADDR_W  address
- LOC_DATA_I  in  32  write data
- LOC_BE_I  in  4  byte enables
- LOC_ACK_O  out  1  completion pulse
- LOC_DATA_O  out  32  read data
- LOC_BUSY_O  out  1  transaction in progress
REQ-006 SHALL have the RAM-side ports: RAM_ADD_O out ADDR_W; RAM_DATA_O out 32; RAM_WEN_O out 4; RAM_DATA_I in 32 (synchronous RAM, 1-cycle read latency); STARVE_O out 1 (local starvation flag).

Function
REQ-007 SHALL give the PCI side absolute priority: while HP_MEM_IDLE_I=0, RAM_ADD_O, RAM_DATA_O and RAM_WEN_O SHALL equal the PCI_RAM_* inputs combinationally, with zero added latency.
REQ-008 SHALL drive PCI_RAM_DATA_O = RAM_DATA_I at all times.
REQ-009 SHALL implement the local FSM with states IDLE, PEND, RDWAIT and DONE.
REQ-010 In IDLE, when LOC_REQ_I=1, SHALL latch LOC_WE_I, LOC_ADD_I, LOC_DATA_I and LOC_BE_I into holding registers and go to PEND; LOC_REQ_I SHALL be ignored in every state other than IDLE.
REQ-011 In PEND with HP_MEM_IDLE_I=1, SHALL drive the RAM from the holding registers, with RAM_WEN_O = BE for a write or 4'b0000 for a read, then go to DONE for a write or RDWAIT for a read.
REQ-012 In PEND with HP_MEM_IDLE_I=0, SHALL remain in PEND and not drive the RAM, per REQ-007.
REQ-013 In RDWAIT, SHALL register RAM_DATA_I into LOC_DATA_O and go to DONE, regardless of HP_MEM_IDLE_I.
REQ-014 In DONE, SHALL assert LOC_ACK_O=1 for exactly one cycle and return to IDLE.
REQ-015 LOC_DATA_O SHALL hold its value until the next read capture.
REQ-016 With HP_MEM_IDLE_I=1 throughout, latency from the LOC_REQ_I cycle to the LOC_ACK_O cycle SHALL be 2 cycles for a write and 3 cycles for a read.
REQ-017 When HP_MEM_IDLE_I=1 and the FSM is not issuing in PEND, RAM_WEN_O SHALL be 4'b0000 and RAM_ADD_O/RAM_DATA_O SHALL follow the PCI_RAM_* inputs.
REQ-018 If HP_MEM_IDLE_I falls in the same cycle a local access would issue, the PCI side SHALL win and the local access SHALL stay in PEND; no partial write is permitted.
REQ-019 LOC_BUSY_O SHALL be 1 in every state except IDLE.
REQ-020 A LOC_REQ_I arriving in the DONE cycle SHALL be dropped; the requester re-strobes after LOC_ACK_O.

Reset
REQ-021 On PHY_RSTn_I=0, the block SHALL immediately, asynchronously enter IDLE and clear LOC_ACK_O, LOC_BUSY_O, LOC_DATA_O, STARVE_O, the holding registers and the starvation counter to 0.
REQ-022 A reset asserted mid-transaction SHALL abort it with no RAM write and no LOC_ACK_O.
REQ-023 Release of reset SHALL be sampled on the rising edge of PHY_CLK33_I.

Configuration
REQ-024 With macro HPRAM_ARB_STARVE_EN defined, the block SHALL count consecutive PEND cycles blocked by HP_MEM_IDLE_I=0 in an 8-bit saturating counter.
REQ-025 With HPRAM_ARB_STARVE_EN defined, STARVE_O SHALL assert when the counter reaches STARVE_LIMIT, remain sticky, and clear, together with the counter, in the DONE cycle.
REQ-026 Without HPRAM_ARB_STARVE_EN, the counter SHALL be absent and STARVE_O SHALL be tied to 0.

Verification
REQ-027 Local write with HP_MEM_IDLE_I=1: ADD=12'h010, DATA=32'hDEADBEEF, BE=4'hF -> RAM_WEN_O=4'hF at cycle+1, LOC_ACK_O at cycle+2, RAM location holds DEADBEEF.
REQ-028 Local read of 12'h010 -> LOC_ACK_O at cycle+3 with LOC_DATA_O=32'hDEADBEEF.
REQ-029 Local read requested while HP_MEM_IDLE_I=0 for 5 cycles, PCI writing 12'h020 -> PCI write unaffected, RAM driven from PCI side only, local access issues on the first idle cycle, LOC_ACK_O 2 cycles after that.
REQ-030 Reset pulse while the FSM is in PEND for a write -> no RAM_WEN_O assertion, LOC_BUSY_O=0 and LOC_ACK_O=0 immediately.
REQ-031 With HPRAM_ARB_STARVE_EN and STARVE_LIMIT=8'd4, hold HP_MEM_IDLE_I=0 for 10 cycles with a local request pending -> STARVE_O=1 from the 4th blocked cycle until the DONE cycle; without the macro STARVE_O stays 0.

Source files
------------

// File: rtl/pci_hpram_arb.sv
// ============================================================================
//  Module      : pci_hpram_arb
//  Description : Arbitrates a single-port HPRAM between the PCI HPMEM manager
//                (absolute priority, zero added latency) and a local
//                requester served by a small IDLE/PEND/RDWAIT/DONE FSM.
//                Optional macro HPRAM_ARB_STARVE_EN adds an 8-bit saturating
//                counter of blocked PEND cycles and a sticky STARVE_O flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pci_hpram_arb #(
  parameter int          ADDR_W       = 12,
  parameter logic [7:0]  STARVE_LIMIT = 8'd200
) (
  input  logic              PHY_CLK33_I,
  input  logic              PHY_RSTn_I,
  // PCI side
  input  logic              HP_MEM_IDLE_I,
  input  logic [ADDR_W-1:0] PCI_RAM_ADD_I,
  input  logic [31:0]       PCI_RAM_DATA_I,
  input  logic [3:0]        PCI_RAM_WEN_I,
  output logic [31:0]       PCI_RAM_DATA_O,
  // Local side
  input  logic              LOC_REQ_I,
  input  logic              LOC_WE_I,
  input  logic [ADDR_W-1:0] LOC_ADD_I,
  input  logic [31:0]       LOC_DATA_I,
  input  logic [3:0]        LOC_BE_I,
  output logic              LOC_ACK_O,
  output logic [31:0]       LOC_DATA_O,
  output logic              LOC_BUSY_O,
  // RAM side
  output logic [ADDR_W-1:0] RAM_ADD_O,
  output logic [31:0]       RAM_DATA_O,
  output logic [3:0]        RAM_WEN_O,
  input  logic [31:0]       RAM_DATA_I,
  output logic              STARVE_O
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PEND   = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state;
  logic              hold_we;
  logic [ADDR_W-1:0] hold_add;
  logic [31:0]       hold_data;
  logic [3:0]        hold_be;
  logic [31:0]       rd_data;
  logic              issue;

  // A local access only reaches the RAM in PEND while the PCI port is free;
  // sampling HP_MEM_IDLE_I combinationally lets the PCI side win a same-cycle
  // collision without any partial local write.
  assign issue = (state == S_PEND) && HP_MEM_IDLE_I;

  // Local access FSM; LOC_REQ_I is only looked at in IDLE.
  always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
    if (!PHY_RSTn_I) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (LOC_REQ_I) state <= S_PEND;
        S_PEND:   if (HP_MEM_IDLE_I) state <= hold_we ? S_DONE : S_RDWAIT;
        S_RDWAIT: state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Capture the request so the requester may change its inputs after the strobe.
  always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
    if (!PHY_RSTn_I) begin
      hold_we   <= 1'b0;
      hold_add  <= '0;
      hold_data <= 32'd0;
      hold_be   <= 4'd0;
    end else if ((state == S_IDLE) && LOC_REQ_I) begin
      hold_we   <= LOC_WE_I;
      hold_add  <= LOC_ADD_I;
      hold_data <= LOC_DATA_I;
      hold_be   <= LOC_BE_I;
    end
  end

  // Read data arrives one cycle after issue; keep it until the next read.
  always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
    if (!PHY_RSTn_I) begin
      rd_data <= 32'd0;
    end else if (state == S_RDWAIT) begin
      rd_data <= RAM_DATA_I;
    end
  end

  // RAM port mux: PCI inputs pass straight through unless the local side is
  // issuing; with the PCI manager idle its write enables are masked off.
  always_comb begin
    RAM_ADD_O  = PCI_RAM_ADD_I;
    RAM_DATA_O = PCI_RAM_DATA_I;
    RAM_WEN_O  = HP_MEM_IDLE_I ? 4'b0000 : PCI_RAM_WEN_I;
    if (issue) begin
      RAM_ADD_O  = hold_add;
      RAM_DATA_O = hold_data;
      RAM_WEN_O  = hold_we ? hold_be : 4'b0000;
    end
  end

  assign PCI_RAM_DATA_O = RAM_DATA_I;
  assign LOC_DATA_O     = rd_data;
  assign LOC_ACK_O      = (state == S_DONE);
  assign LOC_BUSY_O     = (state != S_IDLE);

`ifdef HPRAM_ARB_STARVE_EN
  logic       blocked;
  logic [7:0] starve_cnt;
  logic [8:0] cnt_inc;
  logic       limit_hit;
  logic       starve_r;

  assign blocked   = (state == S_PEND) && !HP_MEM_IDLE_I;
  assign cnt_inc   = {1'b0, starve_cnt} + 9'd1;
  // The flag goes high within the blocked cycle that brings the count to the limit.
  assign limit_hit = blocked && (cnt_inc >= {1'b0, STARVE_LIMIT});

  // Count consecutive blocked PEND cycles, saturating; sticky flag cleared on completion.
  always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
    if (!PHY_RSTn_I) begin
      starve_cnt <= 8'd0;
      starve_r   <= 1'b0;
    end else if (state == S_DONE) begin
      starve_cnt <= 8'd0;
      starve_r   <= 1'b0;
    end else if (blocked) begin
      if (starve_cnt != 8'hFF) starve_cnt <= cnt_inc[7:0];
      if (limit_hit) starve_r <= 1'b1;
    end
  end

  assign STARVE_O = starve_r | limit_hit;
`else
  assign STARVE_O = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pci_hpram_arb.sv
// ============================================================================
//  Module      : tb_pci_hpram_arb
//  Description : Self-checking bench for pci_hpram_arb. Expected local
//                completions (cycle and read data) go into a queue; a monitor
//                pops and compares on every LOC_ACK_O. Other checks are
//                directed against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pci_hpram_arb;

  localparam int ADDR_W = 12;
`ifdef HPRAM_ARB_STARVE_EN
  localparam logic [7:0] LIMIT = 8'd4;
`else
  localparam logic [7:0] LIMIT = 8'd200;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              hp_idle = 1'b1;
  logic [ADDR_W-1:0] pci_add = '0;
  logic [31:0]       pci_data = 32'd0;
  logic [3:0]        pci_wen = 4'd0;
  logic [31:0]       pci_rdata;
  logic              loc_req = 1'b0;
  logic              loc_we = 1'b0;
  logic [ADDR_W-1:0] loc_add = '0;
  logic [31:0]       loc_wdata = 32'd0;
  logic [3:0]        loc_be = 4'd0;
  logic              loc_ack;
  logic [31:0]       loc_rdata;
  logic              loc_busy;
  logic [ADDR_W-1:0] ram_add;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_wen;
  logic [31:0]       ram_rdata = 32'd0;
  logic              starve;

  pci_hpram_arb #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .PHY_CLK33_I    (clk),
    .PHY_RSTn_I     (rst_n),
    .HP_MEM_IDLE_I  (hp_idle),
    .PCI_RAM_ADD_I  (pci_add),
    .PCI_RAM_DATA_I (pci_data),
    .PCI_RAM_WEN_I  (pci_wen),
    .PCI_RAM_DATA_O (pci_rdata),
    .LOC_REQ_I      (loc_req),
    .LOC_WE_I       (loc_we),
    .LOC_ADD_I      (loc_add),
    .LOC_DATA_I     (loc_wdata),
    .LOC_BE_I       (loc_be),
    .LOC_ACK_O      (loc_ack),
    .LOC_DATA_O     (loc_rdata),
    .LOC_BUSY_O     (loc_busy),
    .RAM_ADD_O      (ram_add),
    .RAM_DATA_O     (ram_wdata),
    .RAM_WEN_O      (ram_wen),
    .RAM_DATA_I     (ram_rdata),
    .STARVE_O       (starve)
  );

  always #15 clk = ~clk;

  // Synchronous byte-writable RAM, read-first, one-cycle read latency.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'd0;
  always @(posedge clk) begin
    ram_rdata <= mem[ram_add];
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) mem[ram_add][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at_cyc;
    logic        is_read;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && loc_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack_cycle", cyc, e.at_cyc);
        if (e.is_read) check("read_data", loc_rdata, e.data);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle local strobe; lat = expected cycles to LOC_ACK_O, push=0 when none is due.
  task automatic loc_access(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic [3:0] be, input int lat, input logic [31:0] rd_exp,
                            input logic push);
    exp_t e;
    loc_req = 1'b1; loc_we = we; loc_add = a; loc_wdata = d; loc_be = be;
    e.at_cyc = cyc + lat; e.is_read = ~we; e.data = rd_exp;
    if (push) exp_q.push_back(e);
    tick();
    loc_req = 1'b0; loc_wdata = 32'h0BAD_0BAD;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_ack", loc_ack, 0);
    check("rst_busy", loc_busy, 0);
    check("rst_data", loc_rdata, 0);
    check("rst_starve", starve, 0);
    rst_n = 1'b1;
    tick(2);

    // PCI idle: addresses follow PCI, write enables masked
    pci_add = 12'h3AB; pci_data = 32'h0102_0304; pci_wen = 4'hF;
    #1;
    check("idle_add_follow", ram_add, 12'h3AB);
    check("idle_data_follow", ram_wdata, 32'h0102_0304);
    check("idle_wen_masked", ram_wen, 4'h0);
    pci_wen = 4'h0;

    // Local write, 2-cycle latency
    loc_access(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 2, 32'd0, 1'b1);
    check("wr_wen", ram_wen, 4'hF);
    check("wr_add", ram_add, 12'h010);
    check("wr_busy", loc_busy, 1);
    tick(2);
    check("mem_010", mem[12'h010], 32'hDEADBEEF);

    // Local read, 3-cycle latency
    loc_access(1'b0, 12'h010, 32'd0, 4'hF, 3, 32'hDEADBEEF, 1'b1);
    check("rd_wen_zero", ram_wen, 4'h0);
    tick(3);

    // Partial write then read back merged word
    loc_access(1'b1, 12'h010, 32'h1122_3344, 4'b0011, 2, 32'd0, 1'b1);
    tick(2);
    loc_access(1'b0, 12'h010, 32'd0, 4'hF, 3, 32'hDEAD_3344, 1'b1);
    tick(3);
    check("rd_hold", loc_rdata, 32'hDEAD_3344);

    // PCI busy 5 cycles writing 020 while a local read waits
    hp_idle = 1'b0; pci_add = 12'h020; pci_data = 32'hCAFE_F00D; pci_wen = 4'hF;
    loc_access(1'b0, 12'h010, 32'd0, 4'hF, 8, 32'hDEAD_3344, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("blk_add", ram_add, 12'h020);
      check("blk_wen", ram_wen, 4'hF);
      if (i == 1) begin
        loc_req = 1'b1; loc_we = 1'b1; loc_add = 12'h060; loc_wdata = 32'h6666_6666; loc_be = 4'hF;
      end else begin
        loc_req = 1'b0;
      end
      tick();
    end
    loc_req = 1'b0;
    hp_idle = 1'b1; pci_wen = 4'h0;
    #1;
    check("issue_add", ram_add, 12'h010);
    check("issue_wen", ram_wen, 4'h0);
    tick(3);
    check("pci_mem_020", mem[12'h020], 32'hCAFE_F00D);
    check("pend_req_ignored", mem[12'h060], 32'd0);

    // PCI takes the port in the cycle the local write would issue
    loc_access(1'b1, 12'h040, 32'h55AA_55AA, 4'hF, 3, 32'd0, 1'b0);
    exp_q.push_back('{at_cyc: cyc + 2, is_read: 1'b0, data: 32'd0});
    hp_idle = 1'b0; pci_add = 12'h030; pci_wen = 4'h0;
    #1;
    check("collide_wen", ram_wen, 4'h0);
    check("collide_add", ram_add, 12'h030);
    tick();
    hp_idle = 1'b1;
    tick(3);
    check("mem_040", mem[12'h040], 32'h55AA_55AA);

    // Request in the DONE cycle is dropped
    loc_access(1'b1, 12'h050, 32'h0000_0001, 4'hF, 2, 32'd0, 1'b1);
    tick();
    loc_req = 1'b1; loc_we = 1'b1; loc_add = 12'h058; loc_wdata = 32'h5858_5858; loc_be = 4'hF;
    tick();
    loc_req = 1'b0;
    check("done_req_dropped", loc_busy, 0);
    tick(3);
    check("mem_058", mem[12'h058], 32'd0);

    // Reset while a write is pending
    hp_idle = 1'b0; pci_wen = 4'h0;
    loc_access(1'b1, 12'h070, 32'h1234_5678, 4'hF, 0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", loc_busy, 0);
    check("rst_mid_ack", loc_ack, 0);
    check("rst_mid_data", loc_rdata, 0);
    hp_idle = 1'b1;
    #1;
    check("rst_mid_wen", ram_wen, 4'h0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("mem_070", mem[12'h070], 32'd0);

    // Starvation: 10 blocked cycles with a write pending
    hp_idle = 1'b0; pci_add = 12'h100; pci_wen = 4'h0;
    loc_access(1'b1, 12'h080, 32'hA5A5_0F0F, 4'hF, 12, 32'd0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
`ifdef HPRAM_ARB_STARVE_EN
      check("starve_flag", starve, (i >= 4) ? 1 : 0);
`else
      check("starve_tied", starve, 0);
`endif
      tick();
    end
    hp_idle = 1'b1;
    tick(3);
    check("starve_cleared", starve, 0);
    check("mem_080", mem[12'h080], 32'hA5A5_0F0F);

    // Drain: all expected completions must have been seen
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("exp_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
